// File: rtl/mips_tb_pkg.sv
// Shared types for the MIPS regression store-checking sequencer.
package mips_tb_pkg;

  localparam int unsigned EXP_ADDR_W = 32;
  localparam int unsigned EXP_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_RUN  = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } chk_state_t;

  typedef struct packed {
    logic [EXP_ADDR_W-1:0] addr;
    logic [EXP_DATA_W-1:0] data;
    logic [EXP_DATA_W-1:0] mask;
    logic                  strict;
  } exp_entry_t;

endpackage

// File: rtl/expect_table.sv
// Expected-store table: one entry per test, written by config, read at the current test.
module expect_table
  import mips_tb_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(NUM_TESTS)-1:0] wr_idx,
  input  exp_entry_t                   wr_entry,
  input  logic [$clog2(NUM_TESTS)-1:0] rd_idx,
  output exp_entry_t                   rd_entry_c
);

  exp_entry_t mem [NUM_TESTS];

  // Deliberately unreset: contents are only meaningful once programmed.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_entry;
  end

  assign rd_entry_c = mem[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Sequences core reset/program select per test and scores data-memory stores
// against the expected-store table.
module mem_write_checker
  import mips_tb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_TESTS     = 16,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned WINDOW_CYCLES = 98,
  parameter int unsigned EARLY_EXIT    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [$clog2(NUM_TESTS+1)-1:0]   run_count,
  input  logic                             cfg_we,
  input  logic [$clog2(NUM_TESTS)-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0]                cfg_addr,
  input  logic [DATA_W-1:0]                cfg_data,
  input  logic [DATA_W-1:0]                cfg_mask,
  input  logic                             cfg_strict,
  input  logic                             mem_we,
  input  logic [ADDR_W-1:0]                mem_addr,
  input  logic [DATA_W-1:0]                mem_wdata,
  output logic                             dut_reset,
  output logic [$clog2(NUM_TESTS)-1:0]     test_sel,
  output logic                             busy,
  output logic                             done,
  output logic                             result_valid,
  output logic                             result_pass,
  output logic [NUM_TESTS-1:0]             pass_vec,
  output logic [$clog2(NUM_TESTS+1)-1:0]   pass_cnt,
  output logic [15:0]                      mismatch_cnt,
  output logic [ADDR_W-1:0]                first_bad_addr,
  output logic [DATA_W-1:0]                first_bad_data
);

  localparam int unsigned IDX_W   = $clog2(NUM_TESTS);
  localparam int unsigned CNT_W   = $clog2(NUM_TESTS + 1);
  localparam int unsigned CYC_MAX = (RST_CYCLES > WINDOW_CYCLES) ? RST_CYCLES : WINDOW_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam bit          EARLY   = (EARLY_EXIT != 0);

  chk_state_t       state;
  logic [CYC_W-1:0] cyc;
  logic [CNT_W-1:0] run_len;
  logic             hit;
  logic             fail;
  logic             bad_seen;

  exp_entry_t       wr_entry;
  exp_entry_t       cur_entry;
  logic             tbl_we;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] exp_mask;
  logic              store_match;
  logic              store_bad;
  logic              hit_next;
  logic              fail_next;
  logic              verdict;
  logic              run_end;
  logic              last_test;
  logic [CNT_W-1:0]  run_len_in;

  assign tbl_we   = cfg_we && !busy;
  assign wr_entry = '{addr:   EXP_ADDR_W'(cfg_addr),
                      data:   EXP_DATA_W'(cfg_data),
                      mask:   EXP_DATA_W'(cfg_mask),
                      strict: cfg_strict};

  expect_table #(.NUM_TESTS(NUM_TESTS)) u_table (
    .clk        (clk),
    .we         (tbl_we),
    .wr_idx     (cfg_idx),
    .wr_entry   (wr_entry),
    .rd_idx     (test_sel),
    .rd_entry_c (cur_entry)
  );

  // Per-cycle store scoring against the current entry.
  assign exp_addr    = ADDR_W'(cur_entry.addr);
  assign exp_data    = DATA_W'(cur_entry.data);
  assign exp_mask    = DATA_W'(cur_entry.mask);
  assign store_match = (mem_addr == exp_addr) && (((mem_wdata ^ exp_data) & exp_mask) == '0);
  assign store_bad   = mem_we && !store_match;
  assign hit_next    = hit || (mem_we && store_match);
  assign fail_next   = fail || (store_bad && cur_entry.strict);
  assign verdict     = hit_next && !fail_next;
  assign run_end     = (EARLY && hit_next) || (cyc == CYC_W'(WINDOW_CYCLES - 1));
  assign last_test   = (CNT_W'(test_sel) + CNT_W'(1)) == run_len;
  assign run_len_in  = (run_count > CNT_W'(NUM_TESTS)) ? CNT_W'(NUM_TESTS) : run_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cyc            <= '0;
      run_len        <= '0;
      hit            <= 1'b0;
      fail           <= 1'b0;
      bad_seen       <= 1'b0;
      dut_reset      <= 1'b0;
      test_sel       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result_valid   <= 1'b0;
      result_pass    <= 1'b0;
      pass_vec       <= '0;
      pass_cnt       <= '0;
      mismatch_cnt   <= '0;
      first_bad_addr <= '0;
      first_bad_data <= '0;
    end else begin
      result_valid <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        dut_reset <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              pass_vec       <= '0;
              pass_cnt       <= '0;
              mismatch_cnt   <= '0;
              first_bad_addr <= '0;
              first_bad_data <= '0;
              bad_seen       <= 1'b0;
              test_sel       <= '0;
              cyc            <= '0;
              run_len        <= run_len_in;
              if (run_count == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= ST_RST;
                dut_reset <= 1'b1;
                busy      <= 1'b1;
                done      <= 1'b0;
              end
            end
          end
          ST_RST: begin
            if (cyc == CYC_W'(RST_CYCLES - 1)) begin
              state     <= ST_RUN;
              dut_reset <= 1'b0;
              cyc       <= '0;
              hit       <= 1'b0;
              fail      <= 1'b0;
            end else begin
              cyc <= cyc + CYC_W'(1);
            end
          end
          ST_RUN: begin
            hit  <= hit_next;
            fail <= fail_next;
            if (store_bad) begin
              if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
              if (!bad_seen) begin
                bad_seen       <= 1'b1;
                first_bad_addr <= mem_addr;
                first_bad_data <= mem_wdata;
              end
            end
            // Verdict is published on entry to NEXT so it is visible for that cycle.
            if (run_end) begin
              state        <= ST_NEXT;
              result_valid <= 1'b1;
              result_pass  <= verdict;
              if (verdict) begin
                pass_vec[test_sel] <= 1'b1;
                pass_cnt           <= pass_cnt + CNT_W'(1);
              end
            end else begin
              cyc <= cyc + CYC_W'(1);
            end
          end
          ST_NEXT: begin
            if (last_test) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_RST;
              test_sel  <= test_sel + IDX_W'(1);
              cyc       <= '0;
              dut_reset <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed vector table, hand sequences and
// randomized multi-test runs scored by a schedule-level reference model.
module tb_mem_write_checker;

  localparam int unsigned NT = 16;
  localparam int unsigned RC = 2;
  localparam int unsigned WC = 98;
  localparam int unsigned CW = $clog2(NT + 1);
  localparam int unsigned IW = $clog2(NT);

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [CW-1:0] run_count;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [31:0]   cfg_addr, cfg_data, cfg_mask;
  logic          cfg_strict;
  logic          mem_we;
  logic [31:0]   mem_addr, mem_wdata;
  logic          dut_reset;
  logic [IW-1:0] test_sel;
  logic          busy, done, result_valid, result_pass;
  logic [NT-1:0] pass_vec;
  logic [CW-1:0] pass_cnt;
  logic [15:0]   mismatch_cnt;
  logic [31:0]   first_bad_addr, first_bad_data;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .run_count(run_count),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_mask(cfg_mask), .cfg_strict(cfg_strict), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dut_reset(dut_reset), .test_sel(test_sel), .busy(busy),
    .done(done), .result_valid(result_valid), .result_pass(result_pass),
    .pass_vec(pass_vec), .pass_cnt(pass_cnt), .mismatch_cnt(mismatch_cnt),
    .first_bad_addr(first_bad_addr), .first_bad_data(first_bad_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;

  always @(negedge clk) if (result_valid) rv_cnt <= rv_cnt + 1;

  // Bench copy of the table and per-test store schedules (index = RUN cycle).
  logic [31:0] e_addr [NT];
  logic [31:0] e_data [NT];
  logic [31:0] e_mask [NT];
  bit          e_strict [NT];
  bit          s_we   [NT][WC];
  logic [31:0] s_addr [NT][WC];
  logic [31:0] s_data [NT][WC];
  bit          obs_pass [NT];
  int          obs_end  [NT];

  typedef struct {
    logic [31:0] addr, data, mask;
    bit          strict;
    int          c0;
    logic [31:0] a0, d0;
    int          c1;
    logic [31:0] a1, d1;
    bit          pass;
    int          endc;
    int          mism;
    logic [31:0] fba, fbd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic program_entry(input int t, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] m, input bit s);
    e_addr[t] = a; e_data[t] = d; e_mask[t] = m; e_strict[t] = s;
    cfg_we = 1'b1; cfg_idx = IW'(t); cfg_addr = a; cfg_data = d; cfg_mask = m; cfg_strict = s;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_sched(input int t);
    for (int k = 0; k < int'(WC); k++) begin
      s_we[t][k] = 1'b0; s_addr[t][k] = '0; s_data[t][k] = '0;
    end
  endtask

  task automatic rand_sched(input int t);
    int dens;
    dens = 4 + int'($urandom % 40);
    for (int k = 0; k < int'(WC); k++) begin
      s_we[t][k]   = ($urandom % dens) == 0;
      s_addr[t][k] = ($urandom % 4 != 0) ? e_addr[t] : e_addr[t] ^ (32'h1 << ($urandom % 3));
      s_data[t][k] = ($urandom % 3 == 0) ? e_data[t] : $urandom;
    end
  endtask

  // Scores one test's schedule: first qualifying hit ends the window early.
  task automatic model_test(input int t, output bit pass, output int endc, output int mism,
                            output bit bad, output logic [31:0] ba, output logic [31:0] bd);
    bit hit, fl;
    hit = 0; fl = 0; endc = WC - 1; mism = 0; bad = 0; ba = '0; bd = '0;
    for (int k = 0; k < int'(WC); k++) begin
      if (s_we[t][k]) begin
        if (s_addr[t][k] == e_addr[t] && ((s_data[t][k] ^ e_data[t]) & e_mask[t]) == 32'h0)
          hit = 1;
        else begin
          mism++;
          if (!bad) begin bad = 1; ba = s_addr[t][k]; bd = s_data[t][k]; end
          if (e_strict[t]) fl = 1;
        end
      end
      if (hit) begin endc = k; break; end
    end
    pass = hit && !fl;
  endtask

  // Never-matching store, driven while the checker must ignore the bus.
  task automatic drive_junk(input int t);
    mem_we    = ($urandom % 2) == 1;
    mem_addr  = e_addr[t] ^ 32'h4;
    mem_wdata = $urandom;
  endtask

  task automatic do_run(input int n, input int abort_t);
    int k, cnt, rv0, me, mm, epc, emm;
    bit mp, mb, eb;
    logic [31:0] ma, md, eba, ebd;
    logic [NT-1:0] epv;
    epv = '0; epc = 0; emm = 0; eb = 0; eba = '0; ebd = '0;
    rv0 = rv_cnt;
    run_count = CW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < n; t++) begin
      model_test(t, mp, me, mm, mb, ma, md);
      cnt = 0;
      while (!dut_reset && cnt < 8) begin @(negedge clk); cnt++; end
      chk("rst_asserted", dut_reset, 1);
      if (!dut_reset) return;
      chk("test_sel", test_sel, t);
      cnt = 0;
      while (dut_reset && cnt < int'(RC) + 4) begin drive_junk(t); @(negedge clk); cnt++; end
      chk("rst_len", cnt, RC);
      k = 0;
      while (!result_valid && k < int'(WC) + 4) begin
        if (abort_t == t && k == 10) begin
          abort = 1'b1; mem_we = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_dut_reset", dut_reset, 0);
          chk("abort_done", done, 0);
          chk("abort_pass_vec", pass_vec, epv);
          chk("abort_pass_cnt", pass_cnt, epc);
          chk("abort_rv_pulses", rv_cnt - rv0, t);
          return;
        end
        if (n > 1 && t == 0 && k == 2) begin
          cfg_we = 1'b1; cfg_idx = IW'(n - 1); cfg_addr = ~e_addr[n-1];
          cfg_data = ~e_data[n-1]; cfg_mask = '1; cfg_strict = 1'b1;
        end else cfg_we = 1'b0;
        mem_we = s_we[t][k]; mem_addr = s_addr[t][k]; mem_wdata = s_data[t][k];
        @(negedge clk);
        k++;
      end
      cfg_we = 1'b0;
      chk("result_valid", result_valid, 1);
      chk("end_cycle", k - 1, me);
      chk("result_pass", result_pass, mp);
      obs_pass[t] = result_pass; obs_end[t] = k - 1;
      if (mp) begin epv[t] = 1'b1; epc++; end
      emm += mm;
      if (mb && !eb) begin eb = 1; eba = ma; ebd = md; end
      drive_junk(t);
      @(negedge clk);
      mem_we = 1'b0;
    end
    chk("done", done, 1);
    chk("busy_after", busy, 0);
    chk("pass_vec", pass_vec, epv);
    chk("pass_cnt", pass_cnt, epc);
    chk("mismatch_cnt", mismatch_cnt, emm);
    chk("first_bad_addr", first_bad_addr, eba);
    chk("first_bad_data", first_bad_data, ebd);
    chk("rv_pulses", rv_cnt - rv0, n);
  endtask

  vec_t vt [9];

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; run_count = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_addr = '0; cfg_data = '0; cfg_mask = '0; cfg_strict = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_dut_reset", dut_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_pass_vec", pass_vec, 0);
    chk("rst_counts", {pass_cnt, mismatch_cnt, test_sel}, 0);
    chk("rst_first_bad", {first_bad_addr, first_bad_data}, 0);
    reset = 1'b1;
    @(negedge clk);

    vt[0] = '{32'h12, 32'd21, 32'hFFFF_FFFF, 1'b0, 40, 32'h12, 32'd21, -1, 0, 0, 1'b1, 40, 0, 0, 0};
    vt[1] = '{32'h12, 32'd21, 32'hFFFF_FFFF, 1'b0, -1, 0, 0, -1, 0, 0, 1'b0, 97, 0, 0, 0};
    vt[2] = '{32'h12, 32'd21, 32'hFFFF_FFFF, 1'b0, 10, 32'h50, 32'd7, 20, 32'h12, 32'd21, 1'b1, 20, 1, 32'h50, 32'd7};
    vt[3] = '{32'h12, 32'd21, 32'hFFFF_FFFF, 1'b1, 10, 32'h50, 32'd7, 20, 32'h12, 32'd21, 1'b0, 20, 1, 32'h50, 32'd7};
    vt[4] = '{32'h12, 32'hFF, 32'hFF, 1'b0, 5, 32'h12, 32'h5500_00FF, -1, 0, 0, 1'b1, 5, 0, 0, 0};
    vt[5] = '{32'h12, 32'd21, 32'hFFFF_FFFF, 1'b0, 97, 32'h12, 32'd21, -1, 0, 0, 1'b1, 97, 0, 0, 0};
    vt[6] = '{32'h12, 32'd21, 32'hFFFF_FFFF, 1'b0, 3, 32'h12, 32'd22, -1, 0, 0, 1'b0, 97, 1, 32'h12, 32'd22};
    vt[7] = '{32'h80, 32'h0, 32'h0, 1'b1, 0, 32'h80, 32'hDEAD_BEEF, -1, 0, 0, 1'b1, 0, 0, 0, 0};
    vt[8] = '{32'h12, 32'd21, 32'hFFFF_FFFF, 1'b1, 50, 32'h13, 32'd21, 60, 32'h12, 32'd21, 1'b0, 60, 1, 32'h13, 32'd21};

    for (int i = 0; i < 9; i++) begin
      program_entry(0, vt[i].addr, vt[i].data, vt[i].mask, vt[i].strict);
      clear_sched(0);
      if (vt[i].c0 >= 0) begin
        s_we[0][vt[i].c0] = 1'b1; s_addr[0][vt[i].c0] = vt[i].a0; s_data[0][vt[i].c0] = vt[i].d0;
      end
      if (vt[i].c1 >= 0) begin
        s_we[0][vt[i].c1] = 1'b1; s_addr[0][vt[i].c1] = vt[i].a1; s_data[0][vt[i].c1] = vt[i].d1;
      end
      do_run(1, -1);
      chk($sformatf("tbl%0d_pass", i), obs_pass[0], vt[i].pass);
      chk($sformatf("tbl%0d_end", i), obs_end[0], vt[i].endc);
      chk($sformatf("tbl%0d_pass_cnt", i), pass_cnt, vt[i].pass ? 1 : 0);
      chk($sformatf("tbl%0d_mism", i), mismatch_cnt, vt[i].mism);
      chk($sformatf("tbl%0d_fba", i), first_bad_addr, vt[i].fba);
      chk($sformatf("tbl%0d_fbd", i), first_bad_data, vt[i].fbd);
    end

    // Zero-length run goes straight to DONE.
    run_count = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_dut_reset", dut_reset, 0);
    chk("zero_pass_cnt", pass_cnt, 0);

    // Three tests: pass, timeout, masked pass.
    program_entry(0, 32'h12, 32'd21, 32'hFFFF_FFFF, 1'b0);
    program_entry(1, 32'h20, 32'd9, 32'hFFFF_FFFF, 1'b0);
    program_entry(2, 32'h12, 32'hFF, 32'hFF, 1'b0);
    for (int t = 0; t < 3; t++) clear_sched(t);
    s_we[0][30] = 1'b1; s_addr[0][30] = 32'h12; s_data[0][30] = 32'd21;
    s_we[2][5] = 1'b1; s_addr[2][5] = 32'h12; s_data[2][5] = 32'h5500_00FF;
    do_run(3, -1);
    chk("multi_pass_vec", pass_vec, 16'b101);
    chk("multi_pass_cnt", pass_cnt, 2);

    do_run(3, 1);

    // Simultaneous abort and start: abort wins.
    run_count = CW'(1); start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_dut_reset", dut_reset, 0);

    // Asynchronous reset in the middle of a run; table survives it.
    run_count = CW'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      mem_we = 1'b1; mem_addr = 32'h99; mem_wdata = $urandom;
      @(negedge clk);
    end
    mem_we = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mism", mismatch_cnt, 0);
    chk("midrst_pass_vec", pass_vec, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_run(1, -1);
    chk("after_rst_table_pass", obs_pass[0], 1);

    // Randomized multi-test runs against the schedule model.
    for (int it = 0; it < 25; it++) begin
      int n;
      n = 1 + int'($urandom % 3);
      for (int t = 0; t < n; t++) begin
        logic [31:0] m;
        case ($urandom % 4)
          0: m = 32'hFFFF_FFFF;
          1: m = 32'h0000_00FF;
          2: m = $urandom;
          default: m = 32'h0;
        endcase
        program_entry(t, $urandom & 32'hFC, $urandom, m, ($urandom % 2) == 1);
        rand_sched(t);
      end
      do_run(n, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
